m_axil_master_engine: RTL and testbench

- Synthesizable AXI4-Lite master that turns a simple command/response stream into single AXI4-Lite read or write transactions.
- Successor to the register-test master. It adds parametrised widths, concurrent AW/W issue with independent completion tracking, captured response codes, a per-transaction latency counter, and an optional write-verify readback.
- Sits between a sequencer/CPU-side controller and any AXI4-Lite register slave.
- One transaction in flight at a time.

---
 rtl/m_axil_master_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_m_axil_master_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axil_master_engine.sv
// ---------------------------------------------------------------------------
// m_axil_master_engine
//
// AXI4-Lite master that turns a simple command/response stream into single
// AXI4-Lite read or write transactions, one transaction in flight at a time.
//
// Optional feature macro: M_AXIL_WRITE_VERIFY_EN
//   Defined   : a write with BRESP==OKAY is followed automatically by a read
//               of the same address. RSP_RDATA/RSP_RESP carry the readback
//               data and RRESP, and RSP_MISMATCH flags strobed-byte
//               differences against the written data.
//   Undefined : no readback, RSP_MISMATCH is tied 0, RSP_RDATA is 0 for writes.
//
// Ports
//   ACLK, ARESET        clock, asynchronous active-low reset
//   CMD_*               command stream (valid/ready, write flag, addr, data, strb)
//   RSP_*               response stream (valid/ready, write echo, read data,
//                       captured BRESP/RRESP, verify mismatch, busy latency)
//   AW*, W*, B*         AXI4-Lite write address / write data / write response
//   AR*, R*             AXI4-Lite read address / read data
// ---------------------------------------------------------------------------
module m_axil_master_engine #(
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int LAT_WIDTH        = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_WRITE,
  input  logic [M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic                            RSP_WRITE,
  output logic [M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            RSP_MISMATCH,
  output logic [LAT_WIDTH-1:0]            RSP_LATENCY,
  output logic [M_AXI_ADDR_WIDTH-1:0]     AWADDR,
  output logic                            AWVALID,
  input  logic                            AWREADY,
  output logic [2:0]                      AWPROT,
  output logic [M_AXI_DATA_WIDTH-1:0]     WDATA,
  output logic [M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
  output logic                            WVALID,
  input  logic                            WREADY,
  input  logic [1:0]                      BRESP,
  input  logic                            BVALID,
  output logic                            BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]     ARADDR,
  output logic                            ARVALID,
  input  logic                            ARREADY,
  output logic [2:0]                      ARPROT,
  input  logic [M_AXI_DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                      RRESP,
  input  logic                            RVALID,
  output logic                            RREADY
);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  state_t                          r_state;
  logic                            r_cmd_ready;
  logic                            r_write;
  logic [M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_arvalid;
  logic                            r_rready;
  logic                            r_aw_done;
  logic                            r_w_done;
  logic                            r_b_done;
  logic                            r_rsp_valid;
  logic [M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                      r_rsp_resp;
  logic [LAT_WIDTH-1:0]            r_lat;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_wr_complete;

  assign w_aw_hs = r_awvalid & AWREADY;
  assign w_w_hs  = r_wvalid  & WREADY;
  assign w_b_hs  = r_bready  & BVALID;
  assign w_ar_hs = r_arvalid & ARREADY;
  assign w_r_hs  = r_rready  & RVALID;

  // Handshakes of the current cycle count as done so simultaneous
  // completions finish the write without an extra cycle.
  assign w_wr_complete = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs) &
                         (r_b_done | w_b_hs);

`ifdef M_AXIL_WRITE_VERIFY_EN
  logic                        r_rsp_mismatch;
  logic [1:0]                  w_bresp_now;
  logic [M_AXI_DATA_WIDTH-1:0] w_strb_mask;

  // BRESP may arrive in the same cycle the write completes.
  assign w_bresp_now = w_b_hs ? BRESP : r_rsp_resp;

  // Expand byte strobes into a bit mask for the readback compare.
  always_comb begin
    w_strb_mask = '0;
    for (int i = 0; i < M_AXI_DATA_WIDTH/8; i++) begin
      w_strb_mask[i*8 +: 8] = {8{r_wstrb[i]}};
    end
  end

  assign RSP_MISMATCH = r_rsp_mismatch;
`else
  assign RSP_MISMATCH = 1'b0;
`endif

  // Single FSM owning every register; all AXI and response outputs are
  // registered. CMD_READY comes up one cycle after reset release.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_lat       <= '0;
`ifdef M_AXIL_WRITE_VERIFY_EN
      r_rsp_mismatch <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (r_cmd_ready && CMD_VALID) begin
            r_cmd_ready <= 1'b0;
            r_write     <= CMD_WRITE;
            r_addr      <= CMD_ADDR;
            r_wdata     <= CMD_WDATA;
            r_wstrb     <= CMD_WSTRB;
            r_lat       <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_b_done    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
`ifdef M_AXIL_WRITE_VERIFY_EN
            r_rsp_mismatch <= 1'b0;
`endif
            if (CMD_WRITE) begin
              r_state   <= WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
            end else begin
              r_state   <= RD;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        WR: begin
          if (!(&r_lat)) r_lat <= r_lat + 1'b1;
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_b_hs) begin
            r_bready   <= 1'b0;
            r_b_done   <= 1'b1;
            r_rsp_resp <= BRESP;
          end
          if (w_wr_complete) begin
`ifdef M_AXIL_WRITE_VERIFY_EN
            if (w_bresp_now == 2'b00) begin
              r_state   <= RD;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end else begin
              r_state     <= RSP;
              r_rsp_valid <= 1'b1;
            end
`else
            r_state     <= RSP;
            r_rsp_valid <= 1'b1;
`endif
          end
        end

        RD: begin
          if (!(&r_lat)) r_lat <= r_lat + 1'b1;
          if (w_ar_hs) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
`ifdef M_AXIL_WRITE_VERIFY_EN
            r_rsp_mismatch <= r_write && (RRESP == 2'b00) &&
                              (((RDATA ^ r_wdata) & w_strb_mask) != '0);
`endif
            r_state     <= RSP;
            r_rsp_valid <= 1'b1;
          end
        end

        RSP: begin
          // CMD_READY rises right after the handshake so the next command
          // can be accepted no earlier than the following cycle.
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign CMD_READY   = r_cmd_ready;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_WRITE   = r_write;
  assign RSP_RDATA   = r_rsp_rdata;
  assign RSP_RESP    = r_rsp_resp;
  assign RSP_LATENCY = r_lat;
  assign AWADDR      = r_addr;
  assign AWVALID     = r_awvalid;
  assign AWPROT      = 3'b000;
  assign WDATA       = r_wdata;
  assign WSTRB       = r_wstrb;
  assign WVALID      = r_wvalid;
  assign BREADY      = r_bready;
  assign ARADDR      = r_addr;
  assign ARVALID     = r_arvalid;
  assign ARPROT      = 3'b000;
  assign RREADY      = r_rready;

endmodule

// File: tb/tb_m_axil_master_engine.sv
// ---------------------------------------------------------------------------
// tb_m_axil_master_engine
//
// Drives commands into m_axil_master_engine against a small behavioural
// AXI4-Lite slave with programmable ready delays and response codes.
// Expected responses are queued when a command is issued and compared when
// the engine presents its response. Build with M_AXIL_WRITE_VERIFY_EN defined
// to exercise the write-verify readback instead of the plain sequence.
// ---------------------------------------------------------------------------
module tb_m_axil_master_engine;

   typedef struct {
      logic        write;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic [7:0]  lat;
      logic        mismatch;
   } expT;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic        CMD_WRITE = 1'b0;
   logic [31:0] CMD_ADDR = '0;
   logic [31:0] CMD_WDATA = '0;
   logic [3:0]  CMD_WSTRB = '0;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b0;
   logic        RSP_WRITE;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_RESP;
   logic        RSP_MISMATCH;
   logic [7:0]  RSP_LATENCY;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY = 1'b0;
   logic [2:0]  AWPROT;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY = 1'b0;
   logic [1:0]  BRESP = 2'b00;
   logic        BVALID = 1'b0;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY = 1'b0;
   logic [2:0]  ARPROT;
   logic [31:0] RDATA = '0;
   logic [1:0]  RRESP = 2'b00;
   logic        RVALID = 1'b0;
   logic        RREADY;

   int checkCount = 0;
   int errorCount = 0;
   expT expQ[$];

   // slave configuration and bookkeeping
   int          awDelay = 0;
   int          wDelay = 0;
   int          arDelay = 0;
   logic [1:0]  cfgBresp = 2'b00;
   logic [1:0]  cfgRresp = 2'b00;
   logic        rdOverrideEn = 1'b0;
   logic [31:0] rdOverride = '0;
   int          awHs = 0;
   int          wHs = 0;
   int          awVCycles = 0;
   int          wVCycles = 0;

   m_axil_master_engine #(
      .M_AXI_ADDR_WIDTH(32),
      .M_AXI_DATA_WIDTH(32),
      .LAT_WIDTH(8)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
      .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .RSP_MISMATCH(RSP_MISMATCH),
      .RSP_LATENCY(RSP_LATENCY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   // 100 MHz-style free-running clock
   always #5 ACLK = ~ACLK;

   // Hard stop in case something upstream of the bounded waits goes wrong
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Behavioural slave: updates inputs on the falling edge. Handshakes seen
   // in one cycle are retired at the start of the next falling edge, so
   // B/R responses appear the cycle after the address/data handshakes.
   initial begin
      logic [31:0] mem [16];
      logic        pAw, pW, pB, pAr, pR;
      logic        awGot, wGot, arGot;
      int          awCnt, wCnt, arCnt;
      logic [31:0] awAddr, wData, arAddr;
      logic [3:0]  wStrb;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      {pAw, pW, pB, pAr, pR, awGot, wGot, arGot} = '0;
      awCnt = 0; wCnt = 0; arCnt = 0;
      awAddr = '0; wData = '0; arAddr = '0; wStrb = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESET) begin
            {pAw, pW, pB, pAr, pR, awGot, wGot, arGot} = '0;
            awCnt = 0; wCnt = 0; arCnt = 0;
            AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
            BVALID = 1'b0; RVALID = 1'b0;
         end else begin
            if (pAw) begin awGot = 1'b1; awCnt = 0; end
            if (pW)  begin wGot = 1'b1; wCnt = 0; end
            if (pB)  begin BVALID = 1'b0; awGot = 1'b0; wGot = 1'b0; end
            if (pAr) begin arGot = 1'b1; arCnt = 0; end
            if (pR)  begin RVALID = 1'b0; arGot = 1'b0; end

            if (awGot && wGot && !BVALID) begin
               for (int b = 0; b < 4; b++)
                  if (wStrb[b]) mem[awAddr[5:2]][b*8 +: 8] = wData[b*8 +: 8];
               BVALID = 1'b1;
               BRESP = cfgBresp;
            end
            if (arGot && !RVALID) begin
               RVALID = 1'b1;
               RDATA = rdOverrideEn ? rdOverride : mem[arAddr[5:2]];
               RRESP = cfgRresp;
            end

            if (AWVALID) awVCycles++;
            if (WVALID)  wVCycles++;
            AWREADY = 1'b0;
            if (AWVALID && !awGot) begin
               if (awCnt >= awDelay) AWREADY = 1'b1;
               else awCnt++;
            end
            WREADY = 1'b0;
            if (WVALID && !wGot) begin
               if (wCnt >= wDelay) WREADY = 1'b1;
               else wCnt++;
            end
            ARREADY = 1'b0;
            if (ARVALID && !arGot) begin
               if (arCnt >= arDelay) ARREADY = 1'b1;
               else arCnt++;
            end

            pAw = AWVALID && AWREADY;
            pW  = WVALID && WREADY;
            pB  = BVALID && BREADY;
            pAr = ARVALID && ARREADY;
            pR  = RVALID && RREADY;
            if (pAw) begin awAddr = AWADDR; awHs++; end
            if (pW)  begin wData = WDATA; wStrb = WSTRB; wHs++; end
            if (pAr) arAddr = ARADDR;
         end
      end
   end

   // Issue one command; queue its expected response when one is due
   task automatic applyStimulus(input logic write, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                input logic expectRsp, input logic [31:0] expRdata,
                                input logic [1:0] expResp, input logic [7:0] expLat,
                                input logic expMis);
      expT e;
      int n;
      if (expectRsp) begin
         e.write = write; e.rdata = expRdata; e.resp = expResp;
         e.lat = expLat; e.mismatch = expMis;
         expQ.push_back(e);
      end
      @(negedge ACLK);
      CMD_VALID = 1'b1; CMD_WRITE = write; CMD_ADDR = addr;
      CMD_WDATA = data; CMD_WSTRB = strb;
      n = 0;
      while (!CMD_READY && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      if (!CMD_READY) checkOutput("cmdAccept", CMD_READY, 1);
      @(negedge ACLK);
      CMD_VALID = 1'b0;
   endtask

   // Wait for the response, optionally stall it, then pop and compare
   task automatic collectResponse(input int holdCycles);
      expT e;
      int n;
      logic [31:0] snapData;
      logic [1:0]  snapResp;
      n = 0;
      while (!RSP_VALID && n < 1000) begin
         @(negedge ACLK);
         n++;
      end
      checkOutput("rspValid", RSP_VALID, 1);
      snapData = RSP_RDATA;
      snapResp = RSP_RESP;
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge ACLK);
         checkOutput("holdValid", RSP_VALID, 1);
         checkOutput("holdData", {RSP_RESP, RSP_RDATA}, {snapResp, snapData});
         checkOutput("holdCmdReady", CMD_READY, 0);
      end
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("rspWrite", RSP_WRITE, e.write);
         checkOutput("rspRdata", RSP_RDATA, e.rdata);
         checkOutput("rspResp", RSP_RESP, e.resp);
         checkOutput("rspLatency", RSP_LATENCY, e.lat);
         checkOutput("rspMismatch", RSP_MISMATCH, e.mismatch);
      end
      RSP_READY = 1'b1;
      @(negedge ACLK);
      RSP_READY = 1'b0;
      checkOutput("rspValidDrop", RSP_VALID, 0);
      checkOutput("cmdReadyAfterRsp", CMD_READY, 1);
   endtask

   task automatic clearCounters();
      awHs = 0; wHs = 0; awVCycles = 0; wVCycles = 0;
   endtask

   initial begin
      $display("[TB] start");
      #1;
      checkOutput("resetCmdReady", CMD_READY, 0);
      checkOutput("resetValids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID}, 0);
      checkOutput("resetLatency", RSP_LATENCY, 0);
      checkOutput("resetRdata", RSP_RDATA, 0);
      repeat (3) @(negedge ACLK);
      ARESET = 1'b1;
      repeat (2) @(negedge ACLK);
      checkOutput("cmdReadyAfterReset", CMD_READY, 1);
      checkOutput("protConst", {AWPROT, ARPROT}, 0);

`ifdef M_AXIL_WRITE_VERIFY_EN
      // readback matches in the strobed bytes only
      rdOverrideEn = 1'b1; rdOverride = 32'h0000_CCDD;
      applyStimulus(1, 32'h10, 32'hAABB_CCDD, 4'b0011, 1, 32'h0000_CCDD, 2'b00, 8'd4, 0);
      collectResponse(0);
      // low byte differs inside the strobe mask
      rdOverride = 32'h0000_CC00;
      applyStimulus(1, 32'h10, 32'hAABB_CCDD, 4'b0011, 1, 32'h0000_CC00, 2'b00, 8'd4, 1);
      collectResponse(0);
      // failing write skips the readback
      cfgBresp = 2'b10;
      applyStimulus(1, 32'h14, 32'h1234_5678, 4'b1111, 1, 32'h0, 2'b10, 8'd2, 0);
      collectResponse(0);
      cfgBresp = 2'b00;
      // failing readback never reports a mismatch
      cfgRresp = 2'b10; rdOverride = 32'hFFFF_FFFF;
      applyStimulus(1, 32'h18, 32'h0000_0001, 4'b1111, 1, 32'hFFFF_FFFF, 2'b10, 8'd4, 0);
      collectResponse(0);
      cfgRresp = 2'b00; rdOverrideEn = 1'b0;
`else
      // zero-wait write then read back
      clearCounters();
      applyStimulus(1, 32'h04, 32'h0000_0005, 4'b1111, 1, 32'h0, 2'b00, 8'd2, 0);
      collectResponse(0);
      checkOutput("zwAwCount", awHs, 1);
      checkOutput("zwWCount", wHs, 1);
      applyStimulus(0, 32'h04, 32'h0, 4'b0000, 1, 32'h0000_0005, 2'b00, 8'd2, 0);
      collectResponse(0);

      // AWREADY late, WREADY immediate
      awDelay = 3; wDelay = 0; clearCounters();
      applyStimulus(1, 32'h08, 32'h0000_0011, 4'b1111, 1, 32'h0, 2'b00, 8'd5, 0);
      collectResponse(0);
      checkOutput("awLateAwCount", awHs, 1);
      checkOutput("awLateWCount", wHs, 1);
      checkOutput("awLateAwCycles", awVCycles, 4);
      checkOutput("awLateWCycles", wVCycles, 1);

      // WREADY late, AWREADY immediate
      awDelay = 0; wDelay = 3; clearCounters();
      applyStimulus(1, 32'h0C, 32'h0000_0022, 4'b1111, 1, 32'h0, 2'b00, 8'd5, 0);
      collectResponse(0);
      checkOutput("wLateAwCount", awHs, 1);
      checkOutput("wLateWCount", wHs, 1);
      checkOutput("wLateAwCycles", awVCycles, 1);
      checkOutput("wLateWCycles", wVCycles, 4);
      wDelay = 0;

      // error responses pass straight through
      cfgBresp = 2'b10;
      applyStimulus(1, 32'h10, 32'h0000_0033, 4'b1111, 1, 32'h0, 2'b10, 8'd2, 0);
      collectResponse(0);
      cfgBresp = 2'b00; cfgRresp = 2'b11;
      applyStimulus(0, 32'h04, 32'h0, 4'b0000, 1, 32'h0000_0005, 2'b11, 8'd2, 0);
      collectResponse(0);
      cfgRresp = 2'b00;

      // response held off by the consumer
      applyStimulus(0, 32'h04, 32'h0, 4'b0000, 1, 32'h0000_0005, 2'b00, 8'd2, 0);
      collectResponse(4);

      // latency saturates on a long AR stall
      arDelay = 300;
      applyStimulus(0, 32'h04, 32'h0, 4'b0000, 1, 32'h0000_0005, 2'b00, 8'd255, 0);
      collectResponse(0);

      // reset in the middle of a stalled read abandons it
      arDelay = 1000;
      applyStimulus(0, 32'h04, 32'h0, 4'b0000, 0, 32'h0, 2'b00, 8'd0, 0);
      repeat (20) @(negedge ACLK);
      checkOutput("stallArvalid", ARVALID, 1);
      #2 ARESET = 1'b0;
      #1;
      checkOutput("midResetValids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID}, 0);
      checkOutput("midResetCmdReady", CMD_READY, 0);
      checkOutput("midResetLatency", RSP_LATENCY, 0);
      repeat (2) @(negedge ACLK);
      ARESET = 1'b1;
      arDelay = 0;
      repeat (2) @(negedge ACLK);
      checkOutput("cmdReadyAfterMidReset", CMD_READY, 1);
      checkOutput("noRspAfterReset", RSP_VALID, 0);
      applyStimulus(0, 32'h04, 32'h0, 4'b0000, 1, 32'h0000_0005, 2'b00, 8'd2, 0);
      collectResponse(0);
`endif

      checkOutput("queueDrained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
